// File: rtl/vectors_pkg.sv
// Shared constants for the vectors arithmetic/shift reference block.
// Holds the default operand widths, the default shift amounts and the
// quotient value returned on a divide-by-zero.
package vectors_pkg;

   localparam int unsigned AW_DEF  = 4;
   localparam int unsigned BW_DEF  = 3;
   localparam int unsigned XW_DEF  = 8;
   localparam int unsigned SHL_DEF = 1;
   localparam int unsigned SHR_DEF = 1;
   localparam int unsigned SHA_DEF = 2;

   // Quotient returned when the divisor is zero (and on saturation).
   localparam logic [BW_DEF-1:0] DIV0_Q = '1;

endpackage : vectors_pkg

// File: rtl/vectors_divu.sv
// Combinational unsigned restoring divider.
// Ports:
//   dividend_i  AW-bit unsigned dividend
//   divisor_i   BW-bit unsigned divisor
//   quotient_o  BW-bit quotient; all-ones when divisor is zero or when the
//               true quotient does not fit in BW bits
module vectors_divu
   import vectors_pkg::*;
#(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned BW = BW_DEF
) (
   input  logic [AW-1:0] dividend_i,
   input  logic [BW-1:0] divisor_i,
   output logic [BW-1:0] quotient_o
);

   // Partial remainder is one bit wider than the divisor: before each shift it
   // is below the divisor, so after the shift it is below twice the divisor.
   logic [BW:0]   rem;
   logic [AW-1:0] q_full;
   logic          div0;
   logic          sat;

   // Restoring long division, one quotient bit per dividend bit, MSB first.
   always_comb begin
      rem    = '0;
      q_full = '0;
      for (int i = int'(AW) - 1; i >= 0; i--) begin
         rem = {rem[BW-1:0], dividend_i[i]};
         if (rem >= {1'b0, divisor_i}) begin
            rem       = rem - {1'b0, divisor_i};
            q_full[i] = 1'b1;
         end
      end
   end

   assign div0 = (divisor_i == '0);
   // Any quotient bit at or above BW means the result is too large.
   assign sat  = ((q_full >> BW) != '0);

   assign quotient_o = (div0 || sat) ? '1 : q_full[BW-1:0];

endmodule : vectors_divu

// File: rtl/vectors.sv
// Registered arithmetic/shift reference block.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in1, in2        AW-bit unsigned operands
//   in3             BW-bit unsigned multiplier/divisor
//   x               XW-bit shift source
//   out1            in1+in2 (AW+1 bits, MSB is carry)
//   out2            in1-in2 (AW+1-bit two's complement)
//   out3            low AW bits of in1*in3
//   out4            floor(in1/in3), saturated, all-ones on divide-by-zero
//   y1, y2, y3      x<<SHL, x>>SHR (logical), x>>>SHA (signed)
// All outputs are registered; latency is one clock.
module vectors
   import vectors_pkg::*;
#(
   parameter int unsigned AW  = AW_DEF,
   parameter int unsigned BW  = BW_DEF,
   parameter int unsigned XW  = XW_DEF,
   parameter int unsigned SHL = SHL_DEF,
   parameter int unsigned SHR = SHR_DEF,
   parameter int unsigned SHA = SHA_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] in1,
   input  logic [AW-1:0] in2,
   input  logic [BW-1:0] in3,
   input  logic [XW-1:0] x,
   output logic [AW:0]   out1,
   output logic [AW:0]   out2,
   output logic [AW-1:0] out3,
   output logic [BW-1:0] out4,
   output logic [XW-1:0] y1,
   output logic [XW-1:0] y2,
   output logic [XW-1:0] y3
);

   localparam int unsigned PW = AW + BW;

   logic [AW:0]   out1_d, out1_q;
   logic [AW:0]   out2_d, out2_q;
   logic [AW-1:0] out3_d, out3_q;
   logic [BW-1:0] out4_d, out4_q;
   logic [XW-1:0] y1_d, y1_q;
   logic [XW-1:0] y2_d, y2_q;
   logic [XW-1:0] y3_d, y3_q;
   logic [PW-1:0] prod;

   // Quotient path.
   vectors_divu #(
      .AW (AW),
      .BW (BW)
   ) u_divu (
      .dividend_i (in1),
      .divisor_i  (in3),
      .quotient_o (out4_d)
   );

   // Sum/difference are formed at AW+1 bits so carry and sign are kept.
   always_comb begin
      out1_d = {1'b0, in1} + {1'b0, in2};
      out2_d = {1'b0, in1} - {1'b0, in2};
      prod   = PW'(in1) * PW'(in3);
      out3_d = prod[AW-1:0];
      y1_d   = x << SHL;
      y2_d   = x >> SHR;
      y3_d   = XW'($unsigned($signed(x) >>> SHA));
   end

   // Single output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_q <= '0;
         out2_q <= '0;
         out3_q <= '0;
         out4_q <= '0;
         y1_q   <= '0;
         y2_q   <= '0;
         y3_q   <= '0;
      end else begin
         out1_q <= out1_d;
         out2_q <= out2_d;
         out3_q <= out3_d;
         out4_q <= out4_d;
         y1_q   <= y1_d;
         y2_q   <= y2_d;
         y3_q   <= y3_d;
      end
   end

   assign out1 = out1_q;
   assign out2 = out2_q;
   assign out3 = out3_q;
   assign out4 = out4_q;
   assign y1   = y1_q;
   assign y2   = y2_q;
   assign y3   = y3_q;

endmodule : vectors

// File: tb/tb_vectors.sv
// Self-checking bench for vectors: expected results are queued as inputs are
// driven and compared one clock later.
module tb_vectors;
   import vectors_pkg::*;

   typedef struct {
      logic [4:0] out1;
      logic [4:0] out2;
      logic [3:0] out3;
      logic [2:0] out4;
      logic [7:0] y1;
      logic [7:0] y2;
      logic [7:0] y3;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] in1, in2;
   logic [2:0] in3;
   logic [7:0] x;
   logic [4:0] out1, out2;
   logic [3:0] out3;
   logic [2:0] out4;
   logic [7:0] y1, y2, y3;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   exp_t last_exp;

   vectors dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1),
      .in2   (in2),
      .in3   (in3),
      .x     (x),
      .out1  (out1),
      .out2  (out2),
      .out3  (out3),
      .out4  (out4),
      .y1    (y1),
      .y2    (y2),
      .y3    (y3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, want);
      end
   endtask

   // Reference model written with integer arithmetic.
   function automatic exp_t model(input int a, input int b, input int c, input int xx);
      exp_t e;
      int   q;
      e.out1 = 5'(a + b);
      e.out2 = 5'(a - b);
      e.out3 = 4'((a * c) % 16);
      q      = (c == 0) ? 7 : a / c;
      if (q > 7) q = 7;
      e.out4 = 3'(q);
      e.y1   = 8'((xx * 2) % 256);
      e.y2   = 8'(xx / 2);
      e.y3   = (xx >= 128) ? 8'((xx / 4) + 192) : 8'(xx / 4);
      return e;
   endfunction

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, "_out1"}, 32'(out1), 32'(e.out1));
      chk({tag, "_out2"}, 32'(out2), 32'(e.out2));
      chk({tag, "_out3"}, 32'(out3), 32'(e.out3));
      chk({tag, "_out4"}, 32'(out4), 32'(e.out4));
      chk({tag, "_y1"},   32'(y1),   32'(e.y1));
      chk({tag, "_y2"},   32'(y2),   32'(e.y2));
      chk({tag, "_y3"},   32'(y3),   32'(e.y3));
   endtask

   task automatic check_zero(input string tag);
      exp_t z;
      z = '{default: '0};
      check_all(tag, z);
   endtask

   // Pop one expectation after the sampling edge and compare.
   task automatic pop_check(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s got=empty_queue want=entry", tag);
      end else begin
         e = exp_q.pop_front();
         last_exp = e;
         check_all(tag, e);
      end
   endtask

   task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] c, input logic [7:0] xx);
      @(negedge clk);
      in1 = a; in2 = b; in3 = c; x = xx;
      exp_q.push_back(model(int'(a), int'(b), int'(c), int'(xx)));
      pop_check(tag);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      in1 = '0; in2 = '0; in3 = '0; x = '0;
      #1 rst_n = 1'b0;
      #1 check_zero("rst_async");
      repeat (2) @(posedge clk);
      #1 check_zero("rst_held");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, checked against both the model and literal values.
      apply("tp1", 4'b1010, 4'b1111, 3'b010, 8'h4F);
      chk("tp1_lit_out1", 32'(out1), 32'h19);
      chk("tp1_lit_out2", 32'(out2), 32'h1B);
      chk("tp1_lit_out3", 32'(out3), 32'h4);
      chk("tp1_lit_out4", 32'(out4), 32'h5);
      chk("tp1_lit_y1",   32'(y1),   32'h9E);
      chk("tp1_lit_y2",   32'(y2),   32'h27);
      chk("tp1_lit_y3",   32'(y3),   32'h13);

      apply("tp2", 4'd15, 4'd15, 3'd7, 8'h00);
      chk("tp2_lit_out1", 32'(out1), 32'h1E);
      chk("tp2_lit_out2", 32'(out2), 32'h0);
      chk("tp2_lit_out3", 32'(out3), 32'h9);
      chk("tp2_lit_out4", 32'(out4), 32'h2);

      apply("tp3", 4'd0, 4'd15, 3'd0, 8'h00);
      chk("tp3_lit_out2", 32'(out2), 32'h11);
      chk("tp3_lit_out3", 32'(out3), 32'h0);
      chk("tp3_lit_div0", 32'(out4), 32'(DIV0_Q));

      apply("tp4", 4'd15, 4'd0, 3'd1, 8'h80);
      chk("tp4_lit_sat", 32'(out4), 32'h7);
      chk("tp4_lit_y1",  32'(y1),   32'h00);
      chk("tp4_lit_y2",  32'(y2),   32'h40);
      chk("tp4_lit_y3",  32'(y3),   32'hE0);

      apply("tp5", 4'd9, 4'd3, 3'd4, 8'hF0);
      chk("tp5_lit_y3", 32'(y3), 32'hFC);
      chk("tp5_lit_y2", 32'(y2), 32'h78);
      chk("tp5_lit_y1", 32'(y1), 32'hE0);

      // Inputs changing between edges must not disturb registered outputs.
      @(negedge clk);
      in1 = 4'd3; in2 = 4'd1; in3 = 3'd3; x = 8'h11;
      #2 check_all("hold", last_exp);
      exp_q.push_back(model(3, 1, 3, 32'h11));
      pop_check("hold_next");

      // Asynchronous reset between edges, then recovery on the next edge.
      #2 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      @(posedge clk);
      #1 check_zero("rst_mid_held");
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(3, 1, 3, 32'h11));
      pop_check("rst_release");

      // Random sweep including every divisor value.
      for (int i = 0; i < 60; i++) begin
         apply("rnd", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               3'(i % 8), 8'($urandom_range(0, 255)));
      end

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover got=%0d want=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_vectors
